// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: ROM address/data, branch redirect and the decode handshake.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_instr;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  // Fetch stage side
  modport master (
    output rom_addr,
    input  rom_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  // ROM / decode / branch-unit side
  modport slave (
    input  rom_addr,
    output rom_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register drives a one-cycle synchronous ROM; returned words land in a
// 2-entry buffer presented to decode over valid/ready. Redirect flushes everything in flight.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.master bus
);

  localparam int unsigned EntW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]        occ_q, occ_d;
  // Entry 0 is always the head; entries are {pc, instr}.
  logic [EntW-1:0]   ent_q [2];
  logic [EntW-1:0]   ent_d [2];

  logic            pop;
  logic            push;
  logic            issue;
  logic [EntW-1:0] new_ent;

  assign bus.rom_addr  = pc_q;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_pc    = ent_q[0][EntW-1:DATA_W];
  assign bus.out_instr = ent_q[0][DATA_W-1:0];

  assign pop     = bus.out_valid && bus.out_ready;
  assign push    = inflight_q;
  assign new_ent = {inflight_pc_q, bus.rom_instr};
  // Only issue when the word would still have a buffer slot on arrival.
  assign issue   = !bus.redirect_valid &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  // Next-state: buffer push/pop, PC advance, redirect flush
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    occ_d         = occ_q;
    ent_d[0]      = ent_q[0];
    ent_d[1]      = ent_q[1];
    if (bus.redirect_valid) begin
      occ_d      = 2'd0;
      inflight_d = 1'b0;
      pc_d       = bus.redirect_pc;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          ent_d[occ_q[0]] = new_ent;
          occ_d           = occ_q + 2'd1;
        end
        2'b01: begin
          ent_d[0] = ent_q[1];
          occ_d    = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            ent_d[0] = new_ent;
          end else begin
            ent_d[0] = ent_q[1];
            ent_d[1] = new_ent;
          end
        end
        default: ;
      endcase
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      occ_q         <= 2'd0;
      ent_q[0]      <= '0;
      ent_q[1]      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      occ_q         <= occ_d;
      ent_q[0]      <= ent_d[0];
      ent_q[1]      <= ent_d[1];
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM model plus a queue-based transaction model of the fetch stage.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_fetch_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  instr_fetch #(.ADDR_W(10), .DATA_W(32), .RESET_PC(10'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_val(input int unsigned a);
    return 32'(a * 4 + 32'h13);
  endfunction

  // Synchronous ROM: data for the address sampled at the previous edge
  always @(posedge clk) bus.rom_instr <= rom_val(int'(bus.rom_addr));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: buffered PCs, the one read in flight, and the next PC to fetch
  int unsigned m_q[$];
  bit          m_pend;
  int unsigned m_pend_pc;
  int unsigned m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend    = 1'b0;
    m_pend_pc = 0;
    m_pc      = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("rom_addr", 32'(bus.rom_addr), m_pc);
    if (m_q.size() != 0) begin
      chk("out_pc", 32'(bus.out_pc), m_q[0]);
      chk("out_instr", bus.out_instr, rom_val(m_q[0]));
    end
  endtask

  // One clock: drive inputs, step the model across the edge, check just after it
  task automatic cycle(input logic rdy, input logic rv, input int unsigned rpc);
    bit pop;
    bit iss;
    int unsigned outstanding;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = 10'(rpc);
    pop = (m_q.size() != 0) && rdy;
    outstanding = m_q.size() + (m_pend ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    if (rv) begin
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = rpc % 1024;
    end else begin
      iss = (outstanding < 2);
      if (pop) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_pc);
      if (iss) begin
        m_pend    = 1'b1;
        m_pend_pc = m_pc;
        m_pc      = (m_pc + 1) % 1024;
      end else begin
        m_pend = 1'b0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic run_until_head(input int unsigned target);
    bit found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (m_q.size() != 0 && m_q[0] == target) found = 1'b1;
      else cycle(1'b1, 1'b0, 0);
    end
    chk("reach_head", 32'(found), 32'd1);
  endtask

  task automatic reset_checks();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_out_pc", 32'(bus.out_pc), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
  endtask

  int unsigned wrap_seq[4];

  initial begin
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    model_reset();

    // Reset and first stream
    #12;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 0);
    chk("first_edge_valid", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 1'b0, 0);
    chk("second_edge_valid", 32'(bus.out_valid), 32'd1);
    chk("second_edge_pc", 32'(bus.out_pc), 32'd0);
    cycle(1'b1, 1'b0, 0);
    chk("stream_pc1", 32'(bus.out_pc), 32'd1);

    // Backpressure at head 7
    run_until_head(7);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 0);
    chk("stall_head", 32'(bus.out_pc), 32'd7);
    chk("stall_rom_addr", 32'(bus.rom_addr), 32'd9);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 0);
      chk("resume_seq", 32'(bus.out_pc), 32'(8 + i));
    end

    // Redirect while streaming at head 20
    run_until_head(20);
    cycle(1'b1, 1'b1, 300);
    chk("redir_flush", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 1'b0, 0);
    chk("redir_gap", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 1'b0, 0);
    chk("redir_target", 32'(bus.out_pc), 32'd300);

    // PC wrap
    cycle(1'b1, 1'b1, 1021);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    chk("wrap_first", 32'(bus.out_pc), 32'd1021);
    wrap_seq = '{1022, 1023, 0, 1};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 0);
      chk("wrap_seq", 32'(bus.out_pc), wrap_seq[i]);
    end

    // Redirect while full and stalled
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 5);
    chk("full_redir_flush", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0);
    chk("full_redir_head", 32'(bus.out_pc), 32'd5);
    cycle(1'b1, 1'b0, 0);
    chk("full_redir_next", 32'(bus.out_pc), 32'd6);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom % 1024);
    end

    // Asynchronous reset mid-stall
    cycle(1'b1, 1'b1, 40);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 0);
    chk("restart_first_edge", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 0);
      chk("restart_seq", 32'(bus.out_pc), 32'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
